// File: rtl/icache_resp.sv
`default_nettype none
// ============================================================================
// Module   : icache_resp
// Purpose  : Direct-mapped, read-only instruction cache responder for the
//            fetch stage. Hits return combinationally in the request cycle.
//            Misses perform a 4-halfword line fill from main memory through
//            a valid/ready-style read interface, stalling fetch throughout.
//
// Ports    : clk       - clock, all state updates on rising edge
//            rst       - asynchronous, active-high reset
//            Addr      - byte address of the requested instruction
//            Rd        - read request (level-sensitive)
//            DataOut   - instruction word, 16'h0000 when Done=0
//            Done      - DataOut valid this cycle
//            Stall     - request not satisfied; requester holds Addr/Rd
//            CacheHit  - Done came from a tag hit (0 on fill completion)
//            err       - misaligned request (Addr[0]=1)
//            state     - current FSM state encoding (debug)
//            mem_addr  - word address to main memory, 0 when mem_rd=0
//            mem_rd    - memory read request
//            mem_data  - memory read data
//            mem_valid - mem_data valid, only meaningful while mem_rd=1
//
// Revision : 1.0 - initial release
// ============================================================================
module icache_resp #(
    parameter int NUM_LINES = 32,
    parameter int IDX_W     = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic        Rd,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic [2:0]  state,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_data,
    input  logic        mem_valid
);

    localparam int C_TAG_W = 13 - IDX_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL0 = 3'd1,
        S_FILL1 = 3'd2,
        S_FILL2 = 3'd3,
        S_FILL3 = 3'd4,
        S_CMPL  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    // Request address latched on a miss; bit 0 is always 0 for a fill, so
    // it is not stored.
    logic [15:1]         r_req_addr;

    logic [NUM_LINES-1:0] r_valid;
    logic [C_TAG_W-1:0]   r_tag  [NUM_LINES];
    logic [15:0]          r_data [NUM_LINES][4];

    // Address decomposition of the live request
    logic [IDX_W-1:0]    w_idx;
    logic [C_TAG_W-1:0]  w_tag;
    logic [1:0]          w_off;
    logic                w_hit;

    // Address decomposition of the latched request
    logic [IDX_W-1:0]    w_req_idx;
    logic [C_TAG_W-1:0]  w_req_tag;
    logic [1:0]          w_req_off;

    logic [1:0]          w_fill_word;
    logic                w_fill_we;
    logic                w_tag_we;
    logic                w_latch_req;
    logic [15:0]         w_word;

    assign w_off     = Addr[2:1];
    assign w_idx     = Addr[2+IDX_W:3];
    assign w_tag     = Addr[15:3+IDX_W];
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    assign w_req_off = r_req_addr[2:1];
    assign w_req_idx = r_req_addr[2+IDX_W:3];
    assign w_req_tag = r_req_addr[15:3+IDX_W];

    // ------------------------------------------------------------------
    // State and request-address registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_req_addr <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_latch_req) begin
                r_req_addr <= Addr[15:1];
            end
        end
    end

    // Valid bits are the only reset storage: clearing them on reset is what
    // guarantees a partially filled line never becomes visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_tag_we) begin
            r_valid[w_req_idx] <= 1'b1;
        end
    end

    // Tag and data arrays, not reset
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_data[w_req_idx][w_fill_word] <= mem_data;
        end
        if (w_tag_we) begin
            r_tag[w_req_idx] <= w_req_tag;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        Done         = 1'b0;
        Stall        = 1'b0;
        CacheHit     = 1'b0;
        err          = 1'b0;
        mem_rd       = 1'b0;
        w_word       = 16'h0000;
        w_fill_word  = 2'd0;
        w_fill_we    = 1'b0;
        w_tag_we     = 1'b0;
        w_latch_req  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (Rd) begin
                    if (Addr[0]) begin
                        err = 1'b1;
                    end else if (w_hit) begin
                        Done     = 1'b1;
                        CacheHit = 1'b1;
                        w_word   = r_data[w_idx][w_off];
                    end else begin
                        Stall        = 1'b1;
                        w_latch_req  = 1'b1;
                        w_next_state = S_FILL0;
                    end
                end
            end

            // FILLk encodes as k+1, so the word index and the successor
            // state both fall out of the encoding (FILL3 + 1 = CMPL).
            S_FILL0, S_FILL1, S_FILL2, S_FILL3: begin
                mem_rd      = 1'b1;
                Stall       = 1'b1;
                w_fill_word = 2'(r_state - 3'd1);
                if (mem_valid) begin
                    w_fill_we    = 1'b1;
                    w_next_state = state_t'(r_state + 3'd1);
                end
            end

            S_CMPL: begin
                Done         = 1'b1;
                w_tag_we     = 1'b1;
                w_word       = r_data[w_req_idx][w_req_off];
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // While reset is held the handshake outputs read as idle even if
        // fetch keeps asserting a request.
        if (rst) begin
            Done      = 1'b0;
            Stall     = 1'b0;
            CacheHit  = 1'b0;
            err       = 1'b0;
            mem_rd    = 1'b0;
            w_fill_we = 1'b0;
            w_tag_we  = 1'b0;
        end
    end

    assign DataOut  = Done ? w_word : 16'h0000;
    assign mem_addr = mem_rd ? {r_req_addr[15:3], w_fill_word, 1'b0} : 16'h0000;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: doc/icache_resp.md
Name: icache_resp

Overview:
- Direct-mapped, read-only instruction cache responder for the fetch stage.
- Serves fetch's instruction-memory request port (Addr/Rd in; DataOut/Done/Stall/CacheHit/err/state out).
- Hits return in the request cycle. Misses run a 4-word line fill from main memory through a valid/ready-style request interface.
- Fetch holds its PC while Stall=1 and injects NOPs, so this block owns all miss timing.

Parameters:
- NUM_LINES, 32, number of cache lines (power of two, 2..256); line = 4 halfwords = 8 bytes.
- IDX_W, 5, log2(NUM_LINES).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- Addr  input  16  byte address of requested instruction
- Rd  input  1  read request, level-sensitive
- DataOut  output  16  instruction word; 16'h0000 when Done=0
- Done  output  1  DataOut valid this cycle
- Stall  output  1  request not satisfied this cycle; requester must hold Addr/Rd
- CacheHit  output  1  Done was served from a tag hit (0 on fill completion)
- err  output  1  misaligned request
- state  output  3  current FSM state encoding (debug)
- mem_addr  output  16  word address to main memory (line base + 2*k)
- mem_rd  output  1  memory read request
- mem_data  input  16  memory read data
- mem_valid  input  1  mem_data valid; counted only while mem_rd=1

Behaviour:
- Address split:
  - offset = Addr[2:1]
  - index = Addr[2+IDX_W:3]
  - tag = Addr[15:3+IDX_W]
  - Addr[0] is the byte bit.
- Storage: per line, valid bit, tag, and 4x16 data words. All valid bits clear on rst; data and tags are not reset.
- States and encodings: IDLE=0, FILL0=1, FILL1=2, FILL2=3, FILL3=4, CMPL=5. Encodings 6–7 are illegal and go to IDLE.
- IDLE with Rd=0: Done=0, Stall=0, CacheHit=0, err=0. No state change.
- IDLE with Rd=1 and Addr[0]=1:
  - err=1, Done=0, Stall=0.
  - No fill, no state change.
- IDLE with Rd=1 and aligned address, on a hit (valid & tag match):
  - Same cycle, combinational: Done=1, CacheHit=1, Stall=0, DataOut = stored word[offset].
  - Stay in IDLE.
- IDLE with Rd=1 and aligned address, on a miss:
  - Stall=1, Done=0.
  - Latch Addr into req_addr and go to FILL0.
- FILLk (k=0..3):
  - mem_rd=1, mem_addr = {req_addr[15:3], k[1:0], 1'b0}, Stall=1.
  - Hold mem_addr stable until mem_valid=1.
  - On a cycle with mem_valid=1, write mem_data into line[index].word[k] and advance to FILL(k+1) (FILL3 goes to CMPL).
  - Memory latency is arbitrary, including zero-wait (mem_valid in the first cycle of the state).
- CMPL:
  - Write tag and set valid for the line.
  - Done=1, CacheHit=0, Stall=0, DataOut = filled word[req_addr offset].
  - mem_rd=0. Go to IDLE.
- Miss latency with zero-wait memory: Stall high for 5 cycles (miss cycle + FILL0..3), Done in the 6th cycle.
- Request changes during FILL/CMPL are ignored; the fill always uses req_addr.
- A fill overwrites (evicts) any valid line at the same index. No write-back is needed (read-only).
- Reset values (async, also mid-fill):
  - state=IDLE, mem_rd=0, Done=0, Stall=0, CacheHit=0, err=0, DataOut=0, req_addr=0.
  - All valid bits clear, so a partially filled line never becomes valid.
- Outputs are undriven-free: mem_addr=0 whenever mem_rd=0.

Test Plan:
- Cold miss:
  - After rst, hold Rd=1, Addr=0x0000.
  - Memory is zero-wait, returning 0x1111,0x2222,0x3333,0x4444.
  - Required: Stall=1 for cycles 0–4; mem_addr 0x0000,0x0002,0x0004,0x0006; cycle 5 Done=1, CacheHit=0, DataOut=0x1111, state 0→1→2→3→4→5→0.
- Hit after fill:
  - Addr=0x0004, Rd=1.
  - Required: same cycle Done=1, CacheHit=1, Stall=0, DataOut=0x3333, mem_rd=0.
- Slow memory:
  - Miss at 0x0010 with mem_valid 3 cycles after each mem_rd.
  - Required: each FILL state lasts 3 cycles with mem_addr stable; Done in cycle 13 after the miss cycle.
- Conflict eviction (NUM_LINES=32):
  - Fill at 0x0000, then read 0x0100 (same index, new tag).
  - Required: miss and fill from 0x0100..0x0106.
  - Re-reading 0x0000 then misses again.
- Misaligned request:
  - Addr=0x0003, Rd=1.
  - Required: err=1, Done=0, Stall=0, no mem_rd, state stays 0.
- Reset mid-fill:
  - Assert rst during FILL2 of the fill at 0x0020.
  - Required: immediately state=0, mem_rd=0, Stall=0.
  - A subsequent read of 0x0020 misses and performs a full 4-word fill.
